// File: rtl/btn_debouncer.sv
// ---------------------------------------------------------------------------
// BtnDebouncer: conditioning stage for the board push-buttons.
//
// Each raw asynchronous button is passed through a two-flop synchroniser.
// A per-channel FSM then accepts a new level only after the synchronised
// input has differed from the current level for DEBOUNCE_CYCLES consecutive
// cycles. On an accepted press the stage also emits a single-cycle pulse.
//
// Parameters:
//   N_BOTON          number of independent button channels
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a change
//   NB_COUNT         stability counter width (2^NB_COUNT >= DEBOUNCE_CYCLES)
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst          asynchronous active-high reset, clears every flop
//   i_btn        raw button levels, 1 = pressed
//   o_btn_level  debounced, registered button level
//   o_btn_pulse  one-cycle pulse in the first cycle a press is accepted
// ---------------------------------------------------------------------------
module btn_debouncer #(
  parameter int N_BOTON         = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NB_COUNT        = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_BOTON-1:0] i_btn,
  output logic [N_BOTON-1:0] o_btn_level,
  output logic [N_BOTON-1:0] o_btn_pulse
);

  typedef enum logic [1:0] {
    STABLE_LOW   = 2'd0,
    CONFIRM_HIGH = 2'd1,
    STABLE_HIGH  = 2'd2,
    CONFIRM_LOW  = 2'd3
  } state_e;

  // Count value on which the level flips: the edge where the run of
  // mismatching samples would reach DEBOUNCE_CYCLES.
  localparam logic [NB_COUNT-1:0] CNT_LAST = NB_COUNT'(DEBOUNCE_CYCLES - 1);
  localparam logic [NB_COUNT-1:0] CNT_ONE  = NB_COUNT'(1);
  localparam logic [NB_COUNT-1:0] CNT_ZERO = '0;
  // With a one-cycle requirement the first mismatching sample is enough,
  // so the CONFIRM states are skipped entirely.
  localparam bit SINGLE_CYCLE = (DEBOUNCE_CYCLES == 1);

  logic [N_BOTON-1:0] sync1_q;
  logic [N_BOTON-1:0] sync2_q;

  // Two-flop synchroniser for all channels; only sync2_q is consumed later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
    end
  end

  for (genvar k = 0; k < N_BOTON; k++) begin : g_chan
    state_e              state_q, state_d;
    logic [NB_COUNT-1:0] cnt_q, cnt_d;
    logic                level_q, level_d;
    logic                pulse_q, pulse_d;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= STABLE_LOW;
        cnt_q   <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        pulse_q <= pulse_d;
      end
    end

    // Any sample matching the current level sends the FSM back to its
    // STABLE state with a cleared count, so the counter is bounded by
    // CNT_LAST and can never wrap.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      pulse_d = 1'b0;
      unique case (state_q)
        STABLE_LOW: begin
          if (sync2_q[k]) begin
            if (SINGLE_CYCLE) begin
              state_d = STABLE_HIGH;
              level_d = 1'b1;
              pulse_d = 1'b1;
              cnt_d   = CNT_ZERO;
            end else begin
              state_d = CONFIRM_HIGH;
              cnt_d   = CNT_ONE;
            end
          end
        end
        CONFIRM_HIGH: begin
          if (!sync2_q[k]) begin
            state_d = STABLE_LOW;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_HIGH;
            level_d = 1'b1;
            pulse_d = 1'b1;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        STABLE_HIGH: begin
          if (!sync2_q[k]) begin
            if (SINGLE_CYCLE) begin
              state_d = STABLE_LOW;
              level_d = 1'b0;
              cnt_d   = CNT_ZERO;
            end else begin
              state_d = CONFIRM_LOW;
              cnt_d   = CNT_ONE;
            end
          end
        end
        CONFIRM_LOW: begin
          if (sync2_q[k]) begin
            state_d = STABLE_HIGH;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_LOW;
            level_d = 1'b0;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = STABLE_LOW;
          cnt_d   = CNT_ZERO;
          level_d = 1'b0;
        end
      endcase
    end

    assign o_btn_level[k] = level_q;
    assign o_btn_pulse[k] = pulse_q;
  end

endmodule

// File: tb/tb_btn_debouncer.sv
// ---------------------------------------------------------------------------
// Testbench for btn_debouncer with DEBOUNCE_CYCLES=4 and three channels.
// A behavioural model tracks, per channel, how many consecutive synchronised
// samples disagreed with the accepted level; the DUT is compared against it
// on every falling edge, and directed scenarios pin exact latencies.
// ---------------------------------------------------------------------------
module tb_btn_debouncer;

  localparam int N   = 3;
  localparam int D   = 4;
  localparam int NBC = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] i_btn;
  logic [N-1:0] o_btn_level;
  logic [N-1:0] o_btn_pulse;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  btn_debouncer #(
    .N_BOTON        (N),
    .DEBOUNCE_CYCLES(D),
    .NB_COUNT       (NBC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_btn      (i_btn),
    .o_btn_level(o_btn_level),
    .o_btn_pulse(o_btn_pulse)
  );

  always #5 clk = ~clk;

  // Behavioural model: the raw input reaches the decision logic two edges
  // after being sampled (delay line), a channel's run counts consecutive
  // disagreeing samples, and the level flips when the run reaches D.
  logic [N-1:0] delayLine [2];
  logic [N-1:0] mLevel;
  logic [N-1:0] mPulse;
  int           mRun [N];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      delayLine[0] = '0;
      delayLine[1] = '0;
      mLevel       = '0;
      mPulse       = '0;
      for (int k = 0; k < N; k++) mRun[k] = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        mPulse[k] = 1'b0;
        if (delayLine[1][k] != mLevel[k]) begin
          mRun[k] = mRun[k] + 1;
          if (mRun[k] == D) begin
            mLevel[k] = delayLine[1][k];
            mPulse[k] = delayLine[1][k];
            mRun[k]   = 0;
          end
        end else begin
          mRun[k] = 0;
        end
      end
      delayLine[1] = delayLine[0];
      delayLine[0] = i_btn;
    end
  end

  task automatic checkOutput(input string name, input logic [N-1:0] actual,
                             input logic [N-1:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Directed check that pins both the DUT and the model to literals.
  task automatic checkLiteral(input string name, input logic [N-1:0] expLevel,
                              input logic [N-1:0] expPulse);
    checkOutput({name, " level"}, o_btn_level, expLevel);
    checkOutput({name, " pulse"}, o_btn_pulse, expPulse);
    checkOutput({name, " model level"}, mLevel, expLevel);
    checkOutput({name, " model pulse"}, mPulse, expPulse);
  endtask

  // Drive a value at a falling edge and hold it for the given cycles.
  task automatic applyStimulus(input logic [N-1:0] v, input int cycles);
    i_btn = v;
    repeat (cycles) @(negedge clk);
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("model level", o_btn_level, mLevel);
      checkOutput("model pulse", o_btn_pulse, mPulse);
    end
  end

  initial begin
    logic [N-1:0] v;
    rst   = 1'b1;
    i_btn = '0;
    repeat (3) @(negedge clk);
    checkLiteral("reset", 3'b000, 3'b000);
    rst      = 1'b0;
    checking = 1'b1;
    applyStimulus(3'b000, 4);

    // Clean press on channel 0: accepted after edge 5.
    applyStimulus(3'b001, 5);
    checkLiteral("press before edge5", 3'b000, 3'b000);
    applyStimulus(3'b001, 1);
    checkLiteral("press after edge5", 3'b001, 3'b001);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(3'b001, 1);
      checkLiteral("held", 3'b001, 3'b000);
    end

    // Release: level falls with the same latency, no pulse.
    applyStimulus(3'b000, 5);
    checkLiteral("release before edge5", 3'b001, 3'b000);
    applyStimulus(3'b000, 1);
    checkLiteral("release after edge5", 3'b000, 3'b000);
    applyStimulus(3'b000, 8);

    // Bounce on channel 1, then hold.
    applyStimulus(3'b010, 1);
    applyStimulus(3'b000, 1);
    applyStimulus(3'b010, 2);
    applyStimulus(3'b000, 1);
    applyStimulus(3'b010, 5);
    checkLiteral("bounce before accept", 3'b000, 3'b000);
    applyStimulus(3'b010, 1);
    checkLiteral("bounce accept", 3'b010, 3'b010);
    applyStimulus(3'b010, 1);
    checkLiteral("bounce pulse once", 3'b010, 3'b000);
    applyStimulus(3'b000, 10);

    // Glitch of 3 cycles on channel 2 is rejected.
    applyStimulus(3'b100, 3);
    applyStimulus(3'b000, 10);
    checkLiteral("glitch rejected", 3'b000, 3'b000);

    // Simultaneous press on all channels.
    applyStimulus(3'b111, 5);
    checkLiteral("simul before", 3'b000, 3'b000);
    applyStimulus(3'b111, 1);
    checkLiteral("simul accept", 3'b111, 3'b111);
    applyStimulus(3'b111, 1);
    checkLiteral("simul after", 3'b111, 3'b000);
    applyStimulus(3'b000, 10);

    // Reset during confirmation: count discarded, full requalification.
    applyStimulus(3'b001, 3);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 checkLiteral("rst mid confirm", 3'b000, 3'b000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus(3'b001, 5);
    checkLiteral("post rst before", 3'b000, 3'b000);
    applyStimulus(3'b001, 1);
    checkLiteral("post rst accept", 3'b001, 3'b001);
    applyStimulus(3'b001, 1);
    checkLiteral("post rst after", 3'b001, 3'b000);

    // Reset while a level is accepted clears outputs asynchronously; the
    // still-held button then counts as a fresh press.
    #2 rst = 1'b1;
    #1 checkLiteral("async clear", 3'b000, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(3'b001, 5);
    checkLiteral("held thru rst before", 3'b000, 3'b000);
    applyStimulus(3'b001, 1);
    checkLiteral("held thru rst accept", 3'b001, 3'b001);
    applyStimulus(3'b000, 10);

    // Randomised phase: per-channel toggles with hold times around D,
    // plus occasional asynchronous resets.
    v = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 9) < 3) v[k] = ~v[k];
      end
      applyStimulus(v, $urandom_range(1, 8));
      if ($urandom_range(0, 99) == 0) begin
        #($urandom_range(1, 4)) rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
